mdu_seq: RTL and testbench

//  Sequential RV32M multiply/divide unit. Sits beside the combinational ALU in EX and takes the same in1/in2 operands.

---
 rtl/mdu_seq.sv | 184 ++++++++++++++++++
 tb/tb_mdu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV32M multiply/divide unit.
// Multiply is a shift-add of MUL_STEP multiplier bits per cycle into a 2*XLEN
// product. Divide is restoring, one quotient bit per cycle. Operands are
// stored as magnitudes, and the result sign is applied in a single FIX cycle.
// Optional feature macro: MDU_FAST_PATH_EN. When it is defined, trivial
// operands (divide by zero, signed overflow, or multiply by zero) skip the
// iterations.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The input side is accepted only in IDLE (in_ready=1). The output side holds
// out_valid and mdu_out stable until out_ready. flush overrides both sides.
module mdu_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [2:0]      mdu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdu_out,
  output logic            busy
);

  localparam int            CW    = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_N = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0] DIV_N = CW'(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic              neg_q;     // result must be negated in FIX
  logic [XLEN-1:0]   opnd_q;    // |multiplicand| or |divisor|
  logic [XLEN-1:0]   hi_q;      // product high word / partial remainder
  logic [XLEN-1:0]   lo_q;      // multiplier bits / quotient bits
  logic [CW-1:0]     cnt_q;

  // Operand decode at the accept edge.
  logic              accept;
  logic              is_div;
  logic              a_signed, b_signed;
  logic              a_neg, b_neg, b_zero;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              neg_d;

  // One iteration of each datapath.
  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic [XLEN:0]            div_shift, div_diff;

  // Final correction.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign accept   = (state == IDLE) && in_valid && !flush;
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy     = (state != IDLE);

  // Signedness, magnitudes and result sign for the presented op.
  always_comb begin
    is_div   = mdu_op[2];
    a_signed = (mdu_op == 3'd1) || (mdu_op == 3'd2) || (mdu_op == 3'd4) || (mdu_op == 3'd6);
    b_signed = (mdu_op == 3'd1) || (mdu_op == 3'd4) || (mdu_op == 3'd6);
    a_neg    = a_signed && in1[XLEN-1];
    b_neg    = b_signed && in2[XLEN-1];
    b_zero   = (in2 == '0);
    abs_a    = a_neg ? -in1 : in1;
    abs_b    = b_neg ? -in2 : in2;
    // Divide by zero must give an all-ones quotient even for a negative
    // dividend, so the quotient sign is suppressed in that case.
    if (is_div) neg_d = mdu_op[1] ? a_neg : ((a_neg ^ b_neg) && !b_zero);
    else        neg_d = a_neg ^ b_neg;
  end

  // Single-step multiply and restoring divide on the stored magnitudes.
  always_comb begin
    mul_sum   = {{MUL_STEP{1'b0}}, hi_q}
              + ({{MUL_STEP{1'b0}}, opnd_q} * {{XLEN{1'b0}}, lo_q[MUL_STEP-1:0]});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  // Apply the sign, then select the word for the op.
  always_comb begin
    prod = {hi_q, lo_q};
    if (neg_q) prod = -prod;
    quo = neg_q ? -lo_q : lo_q;
    rem = neg_q ? -hi_q : hi_q;
    if (op_q[2])                fix_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                        fix_res = prod[2*XLEN-1:XLEN];
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state. flush wins over every other input.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = CALC;
        CALC:    if (cnt_q == '0) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath registers. A zero-count CALC visit costs one edge. This gives
  // the fast path the same two-edge tail as the full iteration path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q    <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      mdu_out <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= mdu_op;
      neg_q <= neg_d;
      hi_q  <= '0;
      if (is_div) begin
        opnd_q <= abs_b;
        lo_q   <= abs_a;
        cnt_q  <= DIV_N;
      end else begin
        opnd_q <= abs_a;
        lo_q   <= abs_b;
        cnt_q  <= MUL_N;
      end
`ifdef MDU_FAST_PATH_EN
      // Preload the finished magnitudes and skip the iterations.
      if (is_div && b_zero) begin
        hi_q  <= abs_a;
        lo_q  <= '1;
        cnt_q <= '0;
      end else if (is_div && !mdu_op[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1)) begin
        hi_q  <= '0;
        lo_q  <= abs_a;
        cnt_q <= '0;
      end else if (!is_div && ((in1 == '0) || b_zero)) begin
        hi_q  <= '0;
        lo_q  <= '0;
        cnt_q <= '0;
      end
`endif
    end else if (state == CALC && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q[2]) begin
        if (!div_diff[XLEN]) begin
          hi_q <= div_diff[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= div_shift[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= mul_sum[XLEN+MUL_STEP-1:MUL_STEP];
        lo_q <= {mul_sum[MUL_STEP-1:0], lo_q[XLEN-1:MUL_STEP]};
      end
    end else if (state == FIX) begin
      mdu_out <= fix_res;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Testbench for mdu_seq. It applies a vector table of results and latencies
// to a MUL_STEP=1 unit, repeats the multiply vectors on a MUL_STEP=4 unit,
// and runs directed sequences for flush, output back-pressure and async reset.
module tb_mdu_seq;

`ifdef MDU_FAST_PATH_EN
  localparam int FAST_LAT = 2;
`else
  localparam int FAST_LAT = 34;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, flush;
  logic        in_valid, in_valid4, out_ready, out_ready4;
  logic [31:0] in1, in2;
  logic [2:0]  mdu_op;
  logic        in_ready, out_valid, busy;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] mdu_out, mdu_out4;

  mdu_seq #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .mdu_op(mdu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .mdu_out(mdu_out), .busy(busy)
  );

  mdu_seq #(.XLEN(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in1(in1), .in2(in2), .mdu_op(mdu_op),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .mdu_out(mdu_out4), .busy(busy4)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vec [17];

  int   n_vec = 0;
  int   n_err = 0;
  logic busy_gap;

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: present one op, wait for its result, then consume it
  task automatic do_op(input bit w4, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat);
    int n;
    n = 0;
    while (!(w4 ? in_ready4 : in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    mdu_op = op;
    in1    = a;
    in2    = b;
    if (w4) in_valid4 = 1'b1;
    else    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    // Operands are only sampled at accept, so scramble them afterwards.
    in1    = $urandom;
    in2    = $urandom;
    mdu_op = 3'($urandom_range(0, 7));
    busy_gap = 1'b0;
    lat = 0;
    while (!(w4 ? out_valid4 : out_valid) && lat < 200) begin
      if (!(w4 ? busy4 : busy)) busy_gap = 1'b1;
      @(negedge clk);
      lat++;
    end
    res = w4 ? mdu_out4 : mdu_out;
    if (w4) out_ready4 = 1'b1;
    else    out_ready  = 1'b1;
    @(negedge clk);
    out_ready  = 1'b0;
    out_ready4 = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          k;
    logic        seen;

    vec[0]  = '{3'd0, 32'd26,        32'd13,        32'h0000_0152, 1'b0};
    vec[1]  = '{3'd0, 32'hFFFF_F82F, 32'hFFFF_F82F, 32'h003D_18A1, 1'b0};
    vec[2]  = '{3'd1, 32'hFFFF_F82F, 32'hFFFF_F82F, 32'h0000_0000, 1'b0};
    vec[3]  = '{3'd3, 32'hFFFF_F82F, 32'hFFFF_F82F, 32'hFFFF_F05E, 1'b0};
    vec[4]  = '{3'd2, 32'hFFFF_F82F, 32'hFFFF_F82F, 32'hFFFF_F82F, 1'b0};
    vec[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vec[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vec[7]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0};
    vec[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vec[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1};
    vec[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vec[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vec[12] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b1};
    vec[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1};
    vec[14] = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0};
    vec[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vec[16] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};

    rstn = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
    in1 = '0; in2 = '0; mdu_op = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_mdu_out",   mdu_out,        32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // table: MUL_STEP=1
    for (int i = 0; i < 17; i++) begin
      do_op(1'b0, vec[i].op, vec[i].a, vec[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vec[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), vec[i].fast ? 32'(FAST_LAT) : 32'd34);
      check($sformatf("vec%0d_busy", i), 32'(busy_gap), 32'd0);
    end

    // table subset: MUL_STEP=4
    for (int i = 1; i < 5; i++) begin
      do_op(1'b1, vec[i].op, vec[i].a, vec[i].b, res, lat);
      check($sformatf("step4_vec%0d_result", i), res, vec[i].exp);
      check($sformatf("step4_vec%0d_latency", i), 32'(lat), 32'd10);
    end

    // flush 10 cycles into a DIV
    mdu_op = 3'd4; in1 = 32'd1000; in2 = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready",  32'(in_ready),  32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_pulse", 32'(seen), 32'd0);
    do_op(1'b0, 3'd0, 32'd3, 32'd4, res, lat);
    check("post_flush_mul", res, 32'd12);

    // flush beats in_valid in IDLE
    mdu_op = 3'd0; in1 = 32'd5; in2 = 32'd6; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_in_ready", 32'(in_ready), 32'd1);
    check("flush_idle_busy",     32'(busy),     32'd0);

    // hold in DONE with out_ready low, then flush beats out_ready
    mdu_op = 3'd0; in1 = 32'd26; in2 = 32'd13; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("hold_reach_done", 32'(out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_mdu_out", c), mdu_out, 32'h0000_0152);
    end
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0;
    check("done_flush_out_valid", 32'(out_valid), 32'd0);
    check("done_flush_in_ready",  32'(in_ready),  32'd1);

    // async reset mid-CALC
    mdu_op = 3'd0; in1 = 32'd26; in2 = 32'd13; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_mdu_out",   mdu_out,        32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_op(1'b0, 3'd7, 32'd100, 32'd7, res, lat);
    check("post_reset_remu", res, 32'd2);
    check("post_reset_lat",  32'(lat), 32'd34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
